// File: rtl/pc_fetch_unit.sv
// Fetch-stage program counter: boot/run/halt control, prioritised redirects,
// valid/ready I-cache handshake and a circular return-address stack.
module pc_fetch_unit #(
  parameter int unsigned     XLEN          = 32,
  parameter logic [XLEN-1:0] RESET_VEC     = XLEN'(32'h0000_1000),
  parameter logic [XLEN-1:0] PANIC_VEC     = XLEN'(32'h0000_2000),
  parameter int unsigned     INSTR_BYTES   = 4,
  parameter int unsigned     RAS_DEPTH     = 4,
  parameter bit              HALT_ON_PANIC = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            exception,
  input  logic [XLEN-1:0] exception_target,
  input  logic            branch,
  input  logic [XLEN-1:0] branch_target,
  input  logic            jump,
  input  logic [XLEN-1:0] jump_target,
  input  logic            call,
  input  logic            ret,
  input  logic            panic,
  input  logic            stall,
  input  logic            fetch_ready,
  output logic [XLEN-1:0] pc_out,
  output logic            pc_valid,
  output logic            ras_empty,
  output logic            ras_full
);

  localparam int unsigned PtrW = $clog2(RAS_DEPTH);
  localparam int unsigned CntW = $clog2(RAS_DEPTH + 1);

  localparam logic [1:0] StBoot = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StHalt = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] ras_q [RAS_DEPTH];
  logic [XLEN-1:0] ras_d [RAS_DEPTH];
  logic [PtrW-1:0] ptr_q, ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [XLEN-1:0] pc_inc;
  logic [PtrW-1:0] top_idx;
  logic            ras_has;

  assign pc_inc  = pc_q + XLEN'(INSTR_BYTES);
  // ptr_q points at the next free slot, so the top entry sits just below it.
  assign top_idx = ptr_q - PtrW'(1);
  assign ras_has = (cnt_q != '0);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ras_d   = ras_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;

    if (exception) begin
      pc_d    = exception_target;
      cnt_d   = '0;
      ptr_d   = '0;
      state_d = StRun;
    end else begin
      case (state_q)
        StBoot: state_d = StRun;
        StRun: begin
          if (stall) begin
            pc_d = pc_q;
          end else if (branch) begin
            pc_d = branch_target;
          end else if (jump) begin
            pc_d = (ret && ras_has) ? ras_q[top_idx] : jump_target;
            if (call && ret && ras_has) begin
              ras_d[top_idx] = pc_inc;
            end else begin
              if (ret && ras_has) begin
                ptr_d = top_idx;
                cnt_d = cnt_q - CntW'(1);
              end
              // A full stack keeps its count; the wrapped pointer overwrites the oldest entry.
              if (call) begin
                ras_d[ptr_q] = pc_inc;
                ptr_d        = ptr_q + PtrW'(1);
                if (cnt_q != CntW'(RAS_DEPTH)) cnt_d = cnt_q + CntW'(1);
              end
            end
          end else if (panic) begin
            pc_d = PANIC_VEC;
            if (HALT_ON_PANIC) state_d = StHalt;
          end else if (fetch_ready) begin
            pc_d = pc_inc;
          end
        end
        StHalt: state_d = StHalt;
        default: state_d = StBoot;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StBoot;
      pc_q    <= RESET_VEC;
      ptr_q   <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < int'(RAS_DEPTH); i++) ras_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      ras_q   <= ras_d;
    end
  end

  assign pc_out    = pc_q;
  assign pc_valid  = (state_q == StRun);
  assign ras_empty = (cnt_q == '0);
  assign ras_full  = (cnt_q == CntW'(RAS_DEPTH));

endmodule
